// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding, default bus widths, response record
// and the watchdog counter width helper.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // One completed (or aborted) transfer as seen by the requester.
  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  slverr;
    logic                  timeout;
  } apb_rsp_t;

  // Width of a counter that must hold 0..timeout; a disabled watchdog
  // (timeout == 0) still gets a 1-bit counter so no zero-width vector exists.
  function automatic int unsigned wd_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_watchdog.sv
// Wait-state watchdog: counts ACCESS cycles that ended with pready low and
// flags the cycle in which one more wait would exceed the TIMEOUT budget.
module apb_wait_watchdog
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned         CNT_W   = wd_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TIMEOUT);
  // Count value while in the TIMEOUT-th ACCESS cycle (all earlier ones waited).
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise saturating increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so all flops update from pre-edge values, independent of statement order.
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q >= LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns a valid/ready command into one SETUP/ACCESS transfer
// and returns a single-cycle response, with a wait-state watchdog abort.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_slverr,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_slverr_q, rsp_slverr_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              wd_clear, wd_count, wd_expired;

  apb_wait_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (pclk),
    .rst_ni   (presetn),
    .clear_i  (wd_clear),
    .count_i  (wd_count),
    .expired_o(wd_expired)
  );

  // Next state, registered APB outputs and response fields.
  always_comb begin
    state_d       = state_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    wd_clear      = 1'b0;
    wd_count      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        wd_clear = 1'b1;
        state_d  = ACCESS;
      end
      ACCESS: begin
        // Ready takes priority over an expiring watchdog in the same cycle.
        if (pready) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
        end else if (wd_expired) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b0;
          rsp_timeout_d = 1'b1;
        end else begin
          wd_count = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed and random transfers against a
// transfer-level reference model and a small APB RAM slave.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int unsigned TMO = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  // Second instance with the watchdog disabled and a slave that never answers.
  logic        c0_valid = 1'b0, c0_ready, c0_rsp_valid, c0_rsp_slverr, c0_rsp_timeout;
  logic [31:0] c0_rsp_rdata, c0_paddr, c0_pwdata;
  logic        c0_psel, c0_penable, c0_pwrite;
  logic [31:0] c0_prdata = 32'h1234_5678;
  logic        c0_pready = 1'b0, c0_pslverr = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [64];
  apb_rsp_t    prev_rsp;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut0 (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(c0_valid), .cmd_ready(c0_ready), .cmd_write(1'b1),
    .cmd_addr(32'h0000_0021), .cmd_wdata(32'hCAFE_F00D),
    .rsp_valid(c0_rsp_valid), .rsp_rdata(c0_rsp_rdata), .rsp_slverr(c0_rsp_slverr),
    .rsp_timeout(c0_rsp_timeout),
    .psel(c0_psel), .penable(c0_penable), .pwrite(c0_pwrite), .paddr(c0_paddr),
    .pwdata(c0_pwdata), .prdata(c0_prdata), .pready(c0_pready), .pslverr(c0_pslverr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer, called and returning at a falling edge. waits = ACCESS cycles
  // with pready low before the slave answers; hold keeps cmd_valid asserted.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input bit err, input bit hold);
    apb_rsp_t exp;
    bit       tmo;
    bit       done;
    int       n_acc, edges, acc, guard;

    // Reference: the watchdog allows TMO cycles, so TMO or more waits abort.
    tmo       = (TMO != 0) && (waits >= int'(TMO));
    n_acc     = tmo ? int'(TMO) : waits + 1;
    exp.timeout = tmo;
    exp.slverr  = !tmo && err;
    exp.rdata   = (tmo || wr) ? 32'h0 : mem[addr[5:0]];

    check("idle_psel", psel, 1'b0);
    check("idle_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    // Noise outside ACCESS must be ignored.
    pready = 1'b1; pslverr = 1'b1; prdata = $urandom();
    @(posedge pclk); edges = 1;
    @(negedge pclk);
    if (!hold) cmd_valid = 1'b0;
    check("setup_psel", psel, 1'b1);
    check("setup_penable", penable, 1'b0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, wr);
    if (wr) check("setup_pwdata", pwdata, wdata);
    check("setup_cmd_ready", cmd_ready, 1'b0);
    check("pulse_cleared", rsp_valid, 1'b0);
    check("hold_rdata", rsp_rdata, prev_rsp.rdata);
    check("hold_flags", {rsp_slverr, rsp_timeout}, {prev_rsp.slverr, prev_rsp.timeout});

    acc = 0; done = 1'b0; guard = 0;
    while (!done && guard < 300) begin
      guard++;
      @(posedge pclk); edges++;
      @(negedge pclk);
      if (rsp_valid) begin
        done = 1'b1;
      end else begin
        check("access_psel_penable", {psel, penable}, 2'b11);
        check("access_paddr_stable", paddr, addr);
        acc++;
        pready  = (acc > waits);
        pslverr = pready ? err : 1'($urandom());
        prdata  = (pready && !wr) ? mem[addr[5:0]] : $urandom();
      end
    end
    pready = 1'b0; pslverr = 1'b0;

    check("rsp_seen", done, 1'b1);
    check("access_cycles", acc, n_acc);
    check("rsp_latency", edges, 2 + n_acc);
    check("rsp_rdata", rsp_rdata, exp.rdata);
    check("rsp_slverr", rsp_slverr, exp.slverr);
    check("rsp_timeout", rsp_timeout, exp.timeout);
    check("rsp_idle_psel", {psel, penable}, 2'b00);
    check("rsp_cmd_ready", cmd_ready, 1'b1);

    if (wr && !tmo && !err) mem[addr[5:0]] = wdata;
    prev_rsp = exp;
  endtask

  initial begin
    int n_rsp, n_drop;
    for (int i = 0; i < 64; i++) mem[i] = $urandom();
    prev_rsp = '0;

    // Reset state.
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset_apb", {psel, penable, pwrite}, 3'b000);
    check("reset_paddr_pwdata", {paddr, pwdata}, 64'h0);
    check("reset_rsp", {rsp_valid, rsp_slverr, rsp_timeout}, 3'b000);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    presetn = 1'b1;
    @(negedge pclk);

    // Directed transfers.
    xfer(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, 1'b0);     // write, zero wait
    @(negedge pclk);
    xfer(1'b0, 32'd5, 32'h0, 3, 1'b0, 1'b0);            // read back, 3 waits
    xfer(1'b0, 32'd40, 32'h0, 0, 1'b1, 1'b0);           // slave error
    xfer(1'b0, 32'd9, 32'h0, 100, 1'b0, 1'b0);          // watchdog abort
    xfer(1'b0, 32'd10, 32'h0, int'(TMO) - 1, 1'b0, 1'b0); // ready in last allowed cycle
    xfer(1'b1, 32'd11, 32'h5555AAAA, int'(TMO), 1'b0, 1'b0); // one wait too many
    xfer(1'b1, 32'd12, 32'h0000A0A0, 0, 1'b0, 1'b1);    // back-to-back, valid held
    xfer(1'b1, 32'd13, 32'h0000B0B0, 2, 1'b0, 1'b0);
    xfer(1'b0, 32'd12, 32'h0, 1, 1'b0, 1'b0);
    xfer(1'b0, 32'd13, 32'h0, 0, 1'b0, 1'b0);

    // Reset during ACCESS wait states.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd7;
    @(posedge pclk); @(negedge pclk);
    cmd_valid = 1'b0; pready = 1'b0;
    @(posedge pclk); @(negedge pclk);
    @(posedge pclk); @(negedge pclk);
    check("pre_reset_access", {psel, penable}, 2'b11);
    presetn = 1'b0;
    @(posedge pclk); @(negedge pclk);
    check("midreset_psel_penable", {psel, penable}, 2'b00);
    check("midreset_no_rsp", rsp_valid, 1'b0);
    presetn = 1'b1;
    check("midreset_cmd_ready", cmd_ready, 1'b1);
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (rsp_valid || psel) n_rsp++;
    end
    check("midreset_quiet", n_rsp, 0);
    prev_rsp = '0;

    // Random transfers, mixing waits, errors, gaps and back-to-back chains.
    for (int i = 0; i < 25; i++) begin
      bit wr, er, hold;
      int w;
      wr   = 1'($urandom());
      er   = ($urandom_range(0, 3) == 0);
      w    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      hold = (i != 24) && 1'($urandom());
      xfer(wr, 32'($urandom_range(0, 63)), $urandom(), w, er, hold);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge pclk);
    end
    @(negedge pclk);
    check("final_idle", {rsp_valid, psel}, 2'b00);

    // Watchdog disabled: a hung slave holds the transfer with no response.
    c0_valid = 1'b1;
    @(posedge pclk); @(negedge pclk);
    c0_valid = 1'b0;
    check("wd0_setup", {c0_psel, c0_penable, c0_pwrite}, 3'b101);
    check("wd0_paddr_pwdata", {c0_paddr, c0_pwdata}, {32'h0000_0021, 32'hCAFE_F00D});
    n_rsp = 0; n_drop = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge pclk);
      if (c0_rsp_valid) n_rsp++;
      if (!(c0_psel && c0_penable) || c0_ready) n_drop++;
    end
    check("wd0_no_rsp", n_rsp, 0);
    check("wd0_stays_access", n_drop, 0);
    check("wd0_rsp_fields", {c0_rsp_rdata, c0_rsp_slverr, c0_rsp_timeout}, 34'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
